// File: rtl/kd_tree_pkg.sv
// Shared command codes, bus widths and state encoding for the kd-tree root controller.
package kd_tree_pkg;

  localparam int DATA_SIZE = 24;
  localparam int CMD_SIZE  = 5;
  localparam int AXIS_SIZE = 2;

  localparam logic [CMD_SIZE-1:0] CMD_NOP                      = 5'b00000;
  localparam logic [CMD_SIZE-1:0] CMD_RST                      = 5'b11111;
  localparam logic [CMD_SIZE-1:0] CMD_RST_DONE                 = 5'b11110;
  localparam logic [CMD_SIZE-1:0] CMD_CENTER_FILL              = 5'b00001;
  localparam logic [CMD_SIZE-1:0] CMD_CENTER_FILL_DONE         = 5'b00101;
  localparam logic [CMD_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS      = 5'b00010;
  localparam logic [CMD_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS_DONE = 5'b00111;
  localparam logic [CMD_SIZE-1:0] CMD_BUSY                     = 5'b01000;
  localparam logic [CMD_SIZE-1:0] CMD_DNE                      = 5'b10000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RST_W,
    ST_GAP1,
    ST_FILL,
    ST_GAP2,
    ST_AXIS,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Index width for a buffer of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kd_tree_ctrl_if.sv
// Host and root-node signals of the kd-tree root controller; slave is the controller side.
interface kd_tree_ctrl_if;
  import kd_tree_pkg::*;

  logic                 start;
  logic [AXIS_SIZE-1:0] cfg_axis;
  logic                 center_in_valid;
  logic [DATA_SIZE-1:0] center_in;
  logic                 center_in_ready;
  logic [CMD_SIZE-1:0]  cmd_to_root;
  logic [DATA_SIZE-1:0] data_to_root;
  logic [CMD_SIZE-1:0]  cmd_from_root;
  logic [DATA_SIZE-1:0] data_from_root;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [4:0]           fill_count;
  logic [DATA_SIZE-1:0] root_data_dbg;

  modport master (
    output start, cfg_axis, center_in_valid, center_in, cmd_from_root, data_from_root,
    input  center_in_ready, cmd_to_root, data_to_root, busy, done, error, fill_count,
           root_data_dbg
  );

  modport slave (
    input  start, cfg_axis, center_in_valid, center_in, cmd_from_root, data_from_root,
    output center_in_ready, cmd_to_root, data_to_root, busy, done, error, fill_count,
           root_data_dbg
  );

endinterface

// File: rtl/kd_ctrl_center_buf.sv
// Register file holding the cluster centers: one write port, one asynchronous read port.
module kd_ctrl_center_buf
  import kd_tree_pkg::*;
#(
  parameter int NUM_CENTERS = 8,
  parameter int IDX_W       = idx_width(NUM_CENTERS)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [NUM_CENTERS];

  // Contents survive reset on purpose; every sequence reloads them before use.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/kd_tree_ctrl.sv
// Root-level kd-tree sequencer: buffers host centers, then runs rst / center_fill / configure_sort_axis.
// Define KD_CTRL_WATCHDOG_EN to abort any wait phase that exceeds TIMEOUT_CYCLES.
module kd_tree_ctrl
  import kd_tree_pkg::*;
#(
  parameter int NUM_CENTERS    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst,
  kd_tree_ctrl_if.slave bus
);

  localparam int               IDX_W    = idx_width(NUM_CENTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CENTERS - 1);
  localparam logic [4:0]       FILL_MAX = 5'(NUM_CENTERS);

  state_t               state;
  logic [IDX_W-1:0]     load_idx;
  logic [IDX_W-1:0]     fill_idx;
  logic [IDX_W-1:0]     fill_next;
  logic [IDX_W-1:0]     rd_idx;
  logic [DATA_SIZE-1:0] rd_data;
  logic [AXIS_SIZE-1:0] axis_latched;
  logic                 load_fire;
  logic                 in_wait;
  logic                 reply_done;
  logic                 timeout;
  logic                 abort;

  kd_ctrl_center_buf #(.NUM_CENTERS(NUM_CENTERS), .IDX_W(IDX_W)) u_buf (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_idx  (load_idx),
    .wr_data (bus.center_in),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign load_fire = (state == ST_LOAD) && bus.center_in_valid;
  assign fill_next = (fill_idx == LAST_IDX) ? fill_idx : fill_idx + IDX_W'(1);
  // Read ahead so the registered data lines up with the index being issued.
  assign rd_idx    = (state == ST_FILL) ? fill_next : '0;
  assign in_wait   = (state == ST_RST_W) || (state == ST_FILL) || (state == ST_AXIS);

  always_comb begin
    reply_done = 1'b0;
    case (state)
      ST_RST_W: reply_done = (bus.cmd_from_root == CMD_RST_DONE);
      ST_FILL:  reply_done = (bus.cmd_from_root == CMD_CENTER_FILL_DONE);
      ST_AXIS:  reply_done = (bus.cmd_from_root == CMD_CONFIGURE_SORT_AXIS_DONE);
      default:  reply_done = 1'b0;
    endcase
  end

`ifdef KD_CTRL_WATCHDOG_EN
  logic [15:0] phase_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          phase_cnt <= '0;
    else if (in_wait) phase_cnt <= phase_cnt + 16'd1;
    else              phase_cnt <= '0;
  end

  assign timeout = (phase_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
`endif

  // A real completion reply outranks an empty-tree or watchdog abort in the same cycle.
  assign abort = in_wait && !reply_done && ((bus.cmd_from_root == CMD_DNE) || timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      load_idx            <= '0;
      fill_idx            <= '0;
      axis_latched        <= '0;
      bus.center_in_ready <= 1'b0;
      bus.cmd_to_root     <= CMD_NOP;
      bus.data_to_root    <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.error           <= 1'b0;
      bus.fill_count      <= '0;
    end else if (abort) begin
      state            <= ST_ERROR;
      bus.cmd_to_root  <= CMD_NOP;
      bus.data_to_root <= '0;
      bus.busy         <= 1'b0;
      bus.error        <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.start) begin
            state               <= ST_LOAD;
            load_idx            <= '0;
            axis_latched        <= bus.cfg_axis;
            bus.fill_count      <= '0;
            bus.center_in_ready <= 1'b1;
            bus.busy            <= 1'b1;
            bus.done            <= 1'b0;
            bus.error           <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            load_idx <= load_idx + IDX_W'(1);
            if (load_idx == LAST_IDX) begin
              state               <= ST_RST_W;
              bus.center_in_ready <= 1'b0;
              bus.cmd_to_root     <= CMD_RST;
              bus.data_to_root    <= '0;
            end
          end
        end
        ST_RST_W: begin
          if (reply_done) begin
            state           <= ST_GAP1;
            bus.cmd_to_root <= CMD_NOP;
          end
        end
        ST_GAP1: begin
          state            <= ST_FILL;
          fill_idx         <= '0;
          bus.fill_count   <= 5'd1;
          bus.cmd_to_root  <= CMD_CENTER_FILL;
          bus.data_to_root <= rd_data;
        end
        ST_FILL: begin
          if (reply_done) begin
            state            <= ST_GAP2;
            bus.cmd_to_root  <= CMD_NOP;
            bus.data_to_root <= '0;
          end else begin
            fill_idx         <= fill_next;
            bus.data_to_root <= rd_data;
            if (bus.fill_count < FILL_MAX) bus.fill_count <= bus.fill_count + 5'd1;
          end
        end
        ST_GAP2: begin
          state            <= ST_AXIS;
          bus.cmd_to_root  <= CMD_CONFIGURE_SORT_AXIS;
          bus.data_to_root <= {{(DATA_SIZE - AXIS_SIZE){1'b0}}, axis_latched};
        end
        ST_AXIS: begin
          if (reply_done) begin
            state            <= ST_DONE;
            bus.cmd_to_root  <= CMD_NOP;
            bus.data_to_root <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                bus.root_data_dbg <= '0;
    else if (bus.cmd_from_root != CMD_NOP)  bus.root_data_dbg <= bus.data_from_root;
  end

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Directed bench for kd_tree_ctrl with a latency-programmable model of the root node.
// Define KD_CTRL_WATCHDOG_EN for both bench and RTL to exercise the timeout path.
module tb_kd_tree_ctrl;
  import kd_tree_pkg::*;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  kd_tree_ctrl_if bus();

  kd_tree_ctrl #(.NUM_CENTERS(N), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int rst_lat  = 3;
  int fill_lat = 4;
  int axis_lat = 2;
  bit rst_dne  = 1'b0;

  int          phase_cycles = 0;
  logic [4:0]  last_cmd     = CMD_NOP;
  logic [4:0]  cmd_trace [$];
  logic [23:0] fill_data [$];
  logic [4:0]  fill_counts [$];
  logic [23:0] axis_data;

  logic [23:0] centers_a [N] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
  logic [23:0] centers_b [N] = '{24'hA1B2C3, 24'h0F0F0F, 24'h123456, 24'hFEDCBA};
  logic [23:0] centers_c [N] = '{24'hAAAAAA, 24'h555555, 24'hC0FFEE, 24'h00BEEF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Root node model plus trace recorder; replies on the phase_cycles-th cycle of a command.
  always @(negedge clk) begin
    if (bus.cmd_to_root == last_cmd) phase_cycles++;
    else phase_cycles = 1;
    last_cmd = bus.cmd_to_root;
    if (bus.busy && !bus.center_in_ready) cmd_trace.push_back(bus.cmd_to_root);
    if (bus.cmd_to_root == CMD_CENTER_FILL) begin
      fill_data.push_back(bus.data_to_root);
      fill_counts.push_back(bus.fill_count);
    end
    if (bus.cmd_to_root == CMD_CONFIGURE_SORT_AXIS) axis_data = bus.data_to_root;
    bus.cmd_from_root  = CMD_NOP;
    bus.data_from_root = 24'h0;
    case (bus.cmd_to_root)
      CMD_RST:
        if (phase_cycles == rst_lat) bus.cmd_from_root = rst_dne ? CMD_DNE : CMD_RST_DONE;
        else bus.cmd_from_root = CMD_BUSY;
      CMD_CENTER_FILL:
        if (phase_cycles == fill_lat) bus.cmd_from_root = CMD_CENTER_FILL_DONE;
        else bus.cmd_from_root = CMD_BUSY;
      CMD_CONFIGURE_SORT_AXIS:
        if (phase_cycles == axis_lat) bus.cmd_from_root = CMD_CONFIGURE_SORT_AXIS_DONE;
      default: ;
    endcase
  end

  function automatic logic [4:0] exp_cmd(input int i, input int r, input int f);
    if (i < r) return CMD_RST;
    i -= r;
    if (i == 0) return CMD_NOP;
    i -= 1;
    if (i < f) return CMD_CENTER_FILL;
    i -= f;
    if (i == 0) return CMD_NOP;
    return CMD_CONFIGURE_SORT_AXIS;
  endfunction

  task automatic start_seq(input logic [1:0] axis);
    cmd_trace.delete();
    fill_data.delete();
    fill_counts.delete();
    axis_data     = '0;
    bus.start     = 1'b1;
    bus.cfg_axis  = axis;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cfg_axis  = ~axis;
  endtask

  task automatic load_centers(input logic [23:0] c [N], input int gap_at, input int gap_len,
                              output logic gap_ready);
    gap_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        bus.center_in_valid = 1'b0;
        bus.center_in       = 24'hBAD000;
        bus.start           = 1'b1;
        repeat (gap_len) @(negedge clk);
        bus.start           = 1'b0;
        gap_ready           = bus.center_in_ready;
      end
      bus.center_in_valid = 1'b1;
      bus.center_in       = c[i];
      @(negedge clk);
    end
    bus.center_in_valid = 1'b0;
    bus.center_in       = 24'hDEAD00;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done || bus.error) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_cmd(input logic [4:0] c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.cmd_to_root == c) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst                 = 1'b1;
    bus.start           = 1'b0;
    bus.cfg_axis        = 2'd0;
    bus.center_in_valid = 1'b0;
    bus.center_in       = 24'h0;
    repeat (3) @(negedge clk);
    checks++; if (bus.cmd_to_root !== CMD_NOP) begin errors++; $display("[TB] FAIL reset_cmd got %h expected %h", bus.cmd_to_root, CMD_NOP); end
    checks++; if (bus.data_to_root !== 24'h0) begin errors++; $display("[TB] FAIL reset_data got %h expected 0", bus.data_to_root); end
    checks++; if ({bus.busy, bus.done, bus.error, bus.center_in_ready} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 0000", {bus.busy, bus.done, bus.error, bus.center_in_ready}); end
    checks++; if (bus.fill_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_fill_count got %0d expected 0", bus.fill_count); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic;
    logic gr;
    bit   ok;
    bit   bad;
    rst_lat = 3; fill_lat = 4; axis_lat = 2; rst_dne = 1'b0;
    start_seq(2'd2);
    checks++; if (bus.center_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready got %b expected 1", bus.center_in_ready); end
    load_centers(centers_a, -1, 0, gr);
    wait_end(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_end got timeout expected done"); end
    checks++; if ({bus.done, bus.error, bus.busy} !== 3'b100) begin errors++; $display("[TB] FAIL basic_flags got %b expected 100", {bus.done, bus.error, bus.busy}); end
    checks++; if (bus.cmd_to_root !== CMD_NOP) begin errors++; $display("[TB] FAIL basic_done_cmd got %h expected %h", bus.cmd_to_root, CMD_NOP); end
    bad = (fill_data.size() != N);
    for (int i = 0; i < fill_data.size() && !bad; i++) if (fill_data[i] !== centers_a[i]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("[TB] FAIL basic_fill_data got %0d words expected %0d in order", fill_data.size(), N); end
    checks++; if (axis_data !== 24'h000002) begin errors++; $display("[TB] FAIL basic_axis_data got %h expected 000002", axis_data); end
    checks++; if (bus.fill_count !== 5'd4) begin errors++; $display("[TB] FAIL basic_fill_count got %0d expected 4", bus.fill_count); end
    bad = (cmd_trace.size() != rst_lat + fill_lat + axis_lat + 2);
    for (int i = 0; i < cmd_trace.size() && !bad; i++) if (cmd_trace[i] !== exp_cmd(i, rst_lat, fill_lat)) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("[TB] FAIL basic_cmd_trace got %0d entries expected %0d with gaps", cmd_trace.size(), rst_lat + fill_lat + axis_lat + 2); end
  endtask

  task automatic test_load_stall;
    logic gr;
    bit   ok;
    bit   bad;
    rst_lat = 2; fill_lat = 4; axis_lat = 1; rst_dne = 1'b0;
    start_seq(2'd3);
    load_centers(centers_b, 2, 5, gr);
    checks++; if (gr !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready got %b expected 1", gr); end
    wait_end(200, ok);
    checks++; if (!ok || bus.done !== 1'b1) begin errors++; $display("[TB] FAIL stall_done got %b expected 1", bus.done); end
    bad = (fill_data.size() != N);
    for (int i = 0; i < fill_data.size() && !bad; i++) if (fill_data[i] !== centers_b[i]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("[TB] FAIL stall_fill_data got %0d words expected %0d in order", fill_data.size(), N); end
    checks++; if (axis_data !== 24'h000003) begin errors++; $display("[TB] FAIL stall_axis_data got %h expected 000003", axis_data); end
  endtask

  task automatic test_long_fill;
    logic gr;
    bit   ok;
    bit   bad;
    rst_lat = 3; fill_lat = 7; axis_lat = 2; rst_dne = 1'b0;
    start_seq(2'd1);
    load_centers(centers_a, -1, 0, gr);
    wait_end(200, ok);
    checks++; if (!ok || bus.done !== 1'b1) begin errors++; $display("[TB] FAIL long_done got %b expected 1", bus.done); end
    bad = (fill_data.size() != 7);
    for (int i = 0; i < fill_data.size() && !bad; i++) if (fill_data[i] !== centers_a[(i < N) ? i : N - 1]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("[TB] FAIL long_fill_data got %0d words expected 7 ending in 444444", fill_data.size()); end
    bad = (fill_counts.size() != 7);
    for (int i = 0; i < fill_counts.size() && !bad; i++) if (fill_counts[i] !== 5'((i + 1 < N) ? i + 1 : N)) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("[TB] FAIL long_fill_count_seq got %0d samples expected 1,2,3,4,4,4,4", fill_counts.size()); end
    checks++; if (bus.fill_count !== 5'd4) begin errors++; $display("[TB] FAIL long_fill_count got %0d expected 4", bus.fill_count); end
  endtask

  task automatic test_dne_rst;
    logic gr;
    bit   ok;
    bit   bad;
    rst_lat = 2; fill_lat = 4; axis_lat = 2; rst_dne = 1'b1;
    start_seq(2'd0);
    load_centers(centers_b, -1, 0, gr);
    wait_end(100, ok);
    checks++; if (!ok || {bus.error, bus.done, bus.busy} !== 3'b100) begin errors++; $display("[TB] FAIL dne_flags got %b expected 100", {bus.error, bus.done, bus.busy}); end
    checks++; if (bus.cmd_to_root !== CMD_NOP) begin errors++; $display("[TB] FAIL dne_cmd got %h expected %h", bus.cmd_to_root, CMD_NOP); end
    checks++; if (cmd_trace.size() != 2 || fill_data.size() != 0) begin errors++; $display("[TB] FAIL dne_trace got %0d cmds %0d fills expected 2 and 0", cmd_trace.size(), fill_data.size()); end
    rst_dne = 1'b0;
    start_seq(2'd1);
    checks++; if ({bus.center_in_ready, bus.error} !== 2'b10) begin errors++; $display("[TB] FAIL dne_restart got %b expected 10", {bus.center_in_ready, bus.error}); end
    load_centers(centers_a, -1, 0, gr);
    wait_end(200, ok);
    bad = !ok || (bus.done !== 1'b1) || (fill_data.size() != N);
    for (int i = 0; i < fill_data.size() && !bad; i++) if (fill_data[i] !== centers_a[i]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("[TB] FAIL dne_rerun got done=%b fills=%0d expected done=1 fills=%0d", bus.done, fill_data.size(), N); end
  endtask

  task automatic test_reset_mid_fill;
    logic gr;
    bit   ok;
    bit   bad;
    rst_lat = 2; fill_lat = 0; axis_lat = 2; rst_dne = 1'b0;
    start_seq(2'd2);
    load_centers(centers_b, -1, 0, gr);
    wait_cmd(CMD_CENTER_FILL, 50, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_reach_fill got timeout expected fill"); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.cmd_to_root !== CMD_NOP) begin errors++; $display("[TB] FAIL midrst_cmd got %h expected %h", bus.cmd_to_root, CMD_NOP); end
    checks++; if ({bus.busy, bus.done, bus.error, bus.fill_count} !== 8'h00) begin errors++; $display("[TB] FAIL midrst_flags got %b/%0d expected 000/0", {bus.busy, bus.done, bus.error}, bus.fill_count); end
    @(negedge clk);
    rst = 1'b0;
    bus.center_in_valid = 1'b1;
    bus.center_in       = 24'h777777;
    @(negedge clk);
    checks++; if (bus.center_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready got %b expected 0", bus.center_in_ready); end
    bus.center_in_valid = 1'b0;
    fill_lat = 4;
    start_seq(2'd2);
    load_centers(centers_c, -1, 0, gr);
    wait_end(200, ok);
    bad = !ok || (bus.done !== 1'b1) || (fill_data.size() != N);
    for (int i = 0; i < fill_data.size() && !bad; i++) if (fill_data[i] !== centers_c[i]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("[TB] FAIL midrst_reload got done=%b fills=%0d expected fresh centers", bus.done, fill_data.size()); end
  endtask

  task automatic test_axis_hang;
    logic gr;
    bit   ok;
    rst_lat = 3; fill_lat = 4; axis_lat = 0; rst_dne = 1'b0;
    start_seq(2'd1);
    load_centers(centers_a, -1, 0, gr);
    wait_cmd(CMD_CONFIGURE_SORT_AXIS, 60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hang_reach_axis got timeout expected axis"); end
    checks++; if (bus.data_to_root !== 24'h000001) begin errors++; $display("[TB] FAIL hang_axis_data got %h expected 000001", bus.data_to_root); end
`ifdef KD_CTRL_WATCHDOG_EN
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++; if ({bus.error, bus.cmd_to_root} !== {1'b0, CMD_CONFIGURE_SORT_AXIS}) begin errors++; $display("[TB] FAIL wd_before got error=%b cmd=%h expected 0/%h", bus.error, bus.cmd_to_root, CMD_CONFIGURE_SORT_AXIS); end
    @(negedge clk);
    checks++; if ({bus.error, bus.busy, bus.cmd_to_root} !== {2'b10, CMD_NOP}) begin errors++; $display("[TB] FAIL wd_error got error=%b busy=%b cmd=%h expected 1/0/%h", bus.error, bus.busy, bus.cmd_to_root, CMD_NOP); end
`else
    repeat (40) @(negedge clk);
    checks++; if ({bus.busy, bus.error, bus.cmd_to_root} !== {2'b10, CMD_CONFIGURE_SORT_AXIS}) begin errors++; $display("[TB] FAIL hang_stays got busy=%b error=%b cmd=%h expected 1/0/%h", bus.busy, bus.error, bus.cmd_to_root, CMD_CONFIGURE_SORT_AXIS); end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_stall();
    test_long_fill();
    test_dne_rst();
    test_reset_mid_fill();
    test_axis_hang();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got no finish expected summary");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/kd_tree_ctrl.md
Name: kd_tree_ctrl

Overview:
- Root-level sequencer for the kd-tree node array. Drives the top command/data port of the root node.
- Buffers NUM_CENTERS cluster centers from a host stream, then runs the tree bring-up sequence over the node command protocol: rst, center_fill, configure_sort_axis.
- Reports busy/done/error to the host. One instance per tree, between host logic and the root node.

Parameters:
- NUM_CENTERS, 8, centers buffered and streamed into the tree (1..16)
- TIMEOUT_CYCLES, 1024, watchdog limit per phase (used only with KD_CTRL_WATCHDOG_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a sequence; sampled in IDLE or DONE/ERROR only
- cfg_axis  in  2  sort axis broadcast in the AXIS phase; latched at start
- center_in_valid  in  1  host center valid
- center_in  in  24  host center value (packed RGB)
- center_in_ready  out  1  high in LOAD only
- cmd_to_root  out  5  command to the root node's command_from_top
- data_to_root  out  24  data to the root node's data_from_top
- cmd_from_root  in  5  root node's command_to_top
- data_from_root  in  24  root node's data_to_top; unused except for debug capture
- busy  out  1  high in LOAD..AXIS
- done  out  1  high in DONE
- error  out  1  high in ERROR
- fill_count  out  5  centers issued in the current FILL

Behaviour:
- Reset values: all outputs 0; cmd_to_root = nop (5'b00000); state IDLE; counters 0.
- States: IDLE, LOAD, RST_W, GAP1, FILL, GAP2, AXIS, DONE, ERROR.
- IDLE / DONE / ERROR:
  - start=1 -> LOAD, with load_idx=0 and cfg_axis latched.
  - Otherwise hold the state with cmd_to_root=nop.
- LOAD:
  - center_in_ready=1.
  - Each cycle with valid&ready, write buf[load_idx] and increment load_idx.
  - After the NUM_CENTERS-th write, go to RST_W the next cycle.
  - No timeout applies in LOAD.
- RST_W:
  - Drive cmd=rst (5'b11111), data=0.
  - cmd_from_root==rst_done (5'b11110) -> GAP1.
- GAP1:
  - Drive nop for exactly 1 cycle, then FILL with fill_idx=0.
- FILL:
  - Drive cmd=center_fill (5'b00001), data=buf[fill_idx].
  - fill_idx increments every cycle and saturates at NUM_CENTERS-1; the last value is held.
  - fill_count = min(cycles in FILL, NUM_CENTERS).
  - cmd_from_root==center_fill_done (5'b00101) -> GAP2. Same-cycle done and increment: done wins and fill_idx freezes.
- GAP2:
  - Drive nop for 1 cycle, then AXIS.
- AXIS:
  - Drive cmd=configure_sort_axis (5'b00010), data={22'b0, cfg_axis_latched}.
  - cmd_from_root==configure_sort_axis_done (5'b00111) -> DONE.
- Empty tree: cmd_from_root==dne (5'b10000) in RST_W, FILL or AXIS -> ERROR.
- Other responses: any other cmd_from_root value (nop, busy) in a wait state means keep waiting.
- Outputs are registered: cmd/data change 1 cycle after the state transition that selects them.
- start while busy is ignored.
- An asynchronous rst mid-sequence returns to IDLE immediately with cmd_to_root=nop. Buffer contents are not cleared but are not reused; a new LOAD is always performed.
- A center_in_valid that arrives outside LOAD is not accepted (ready=0).

Optional Feature:
- KD_CTRL_WATCHDOG_EN defined:
  - A 16-bit phase counter clears on entry to RST_W, FILL or AXIS and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES -> ERROR, cmd_to_root=nop.
- Undefined: no counter; only dne can cause ERROR.

Decomposition:
- Package kd_tree_pkg:
  - Command localparams nop, rst, rst_done, center_fill, center_fill_done, configure_sort_axis, configure_sort_axis_done, busy, dne.
  - DATA_SIZE=24, CMD_SIZE=5, AXIS_SIZE=2.
  - State encoding.
- One natural sub-module, kd_ctrl_center_buf: an NUM_CENTERS x 24 register buffer with a write port (load_idx) and an asynchronous read port (fill_idx).

Test Plan:
- Reset, then start with NUM_CENTERS=4, centers 0x111111/0x222222/0x333333/0x444444 and a model root that answers rst_done after 3 cycles and center_fill_done after 4 FILL cycles -> data_to_root emits the 4 centers in order; then AXIS with cfg_axis=2 yields data=0x000002; done=1.
- Host deasserts center_in_valid for 5 cycles mid-LOAD -> no writes and load_idx holds; sequence completes with the correct order.
- Root answers center_fill_done only after 7 FILL cycles (NUM_CENTERS=4) -> data_to_root holds 0x444444 from cycle 4 on; fill_count=4.
- Root returns dne during RST_W -> ERROR, error=1, cmd_to_root=nop; start then restarts from LOAD.
- Assert rst during FILL -> next edge cmd_to_root=nop, busy=0, state IDLE.
- With KD_CTRL_WATCHDOG_EN and TIMEOUT_CYCLES=16, root never answers in AXIS -> error=1 after 16 cycles. Without the macro, the controller stays in AXIS indefinitely.
